// File: rtl/serial_add_ctrl_if.sv
// Operand/opcode request and result bus for serial_add_ctrl; zero/overflow exist only with SERIAL_ADD_FLAGS_EN.
// Master issues start with operands; slave answers with busy, a done pulse and held result/carry_out.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef SERIAL_ADD_FLAGS_EN
  logic             zero;
  logic             overflow;

  modport master (output start, op_a, op_b, sub,
                  input  busy, done, result, carry_out, zero, overflow);
  modport slave  (input  start, op_a, op_b, sub,
                  output busy, done, result, carry_out, zero, overflow);
`else
  modport master (output start, op_a, op_b, sub,
                  input  busy, done, result, carry_out);
  modport slave  (input  start, op_a, op_b, sub,
                  output busy, done, result, carry_out);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub around a single add1 cell; SERIAL_ADD_FLAGS_EN adds zero/overflow outputs.
// Latency WIDTH+1 cycles start->done; no backpressure, start is ignored while busy.
module add1 (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic out,
  output logic carry_out
);
  assign out       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  logic             sum_bit;
  logic             sum_cout;
  logic [WIDTH-1:0] res_shift;

  add1 u_add1 (
    .a         (a_sh_q[0]),
    .b         (b_sh_q[0]),
    .carry_in  (carry_q),
    .out       (sum_bit),
    .carry_out (sum_cout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    carry_d   = carry_q;
    result_d  = result_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
    zero_d    = zero_q;
    ovf_d     = ovf_q;
`endif
    res_shift = {sum_bit, res_sh_q[WIDTH-1:1]};

    case (state_q)
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_shift;
        carry_d  = sum_cout;
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = res_shift;
          cout_d   = sum_cout;
`ifdef SERIAL_ADD_FLAGS_EN
          zero_d   = (res_shift == '0);
          // carry_q here is the carry into the MSB
          ovf_d    = carry_q ^ sum_cout;
`endif
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; subtract is A + ~B + 1
        if (bus.start) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.op_b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
`ifdef SERIAL_ADD_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl at WIDTH=4 (exhaustive) and WIDTH=8, against an arithmetic model.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();

  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int         sel = 4;
  logic       drv_start;
  logic [7:0] drv_a, drv_b;
  logic       drv_sub;

  assign bus4.start = drv_start && (sel == 4);
  assign bus4.op_a  = drv_a[3:0];
  assign bus4.op_b  = drv_b[3:0];
  assign bus4.sub   = drv_sub;
  assign bus8.start = drv_start && (sel == 8);
  assign bus8.op_a  = drv_a;
  assign bus8.op_b  = drv_b;
  assign bus8.sub   = drv_sub;

  logic       m_busy, m_done, m_cout;
  logic [7:0] m_res;
  assign m_busy = (sel == 4) ? bus4.busy : bus8.busy;
  assign m_done = (sel == 4) ? bus4.done : bus8.done;
  assign m_cout = (sel == 4) ? bus4.carry_out : bus8.carry_out;
  assign m_res  = (sel == 4) ? {4'b0, bus4.result} : bus8.result;
`ifdef SERIAL_ADD_FLAGS_EN
  logic m_zero, m_ovf;
  assign m_zero = (sel == 4) ? bus4.zero : bus8.zero;
  assign m_ovf  = (sel == 4) ? bus4.overflow : bus8.overflow;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int prev_res  = 0;
  int prev_cout = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (w=%0d t=%0t)", tag, got, exp, sel, $time);
  endtask

  // Plain unsigned arithmetic: subtraction borrows iff a < b
  task automatic model(input int w, input int a, input int b, input int s,
                       output int res, output int cout);
    int mask;
    mask = (1 << w) - 1;
    if (s != 0) begin
      res  = (a - b) & mask;
      cout = (a >= b) ? 1 : 0;
    end else begin
      res  = (a + b) & mask;
      cout = ((a + b) >> w) & 1;
    end
  endtask

  // Call at #1 after an edge with the DUT in IDLE or DONE; returns in the done cycle
  task automatic run_op(input int a, input int b, input int s, input bit noise,
                        output int done_cyc);
    int er, ec, busy_n, done_n, hold_bad;
    model(sel, a, b, s, er, ec);
    drv_start = 1'b1;
    drv_a = 8'(a);
    drv_b = 8'(b);
    drv_sub = s[0];
    @(posedge clk); #1;
    drv_start = 1'b0;
    drv_a = 8'($urandom);
    drv_b = 8'($urandom);
    drv_sub = 1'($urandom);
    busy_n = 0; done_n = 0; hold_bad = 0;
    for (int i = 0; i < sel; i++) begin
      busy_n += int'(m_busy);
      done_n += int'(m_done);
      if (int'(m_res) != prev_res || int'(m_cout) != prev_cout) hold_bad++;
      if (noise) drv_start = 1'($urandom);
      @(posedge clk); #1;
    end
    drv_start = 1'b0;
    chk("busy_cycles", busy_n, sel);
    chk("early_done", done_n, 0);
    chk("result_hold", hold_bad, 0);
    chk("done_pulse", int'(m_done), 1);
    chk("busy_at_done", int'(m_busy), 0);
    chk("result", int'(m_res), er);
    chk("carry_out", int'(m_cout), ec);
`ifdef SERIAL_ADD_FLAGS_EN
    begin
      int msb, sa, sb, sr, eovf;
      msb = 1 << (sel - 1);
      sa = ((a & msb) != 0) ? 1 : 0;
      sb = ((b & msb) != 0) ? 1 : 0;
      sr = ((er & msb) != 0) ? 1 : 0;
      if (s != 0) eovf = (sa != sb && sr != sa) ? 1 : 0;
      else        eovf = (sa == sb && sr != sa) ? 1 : 0;
      chk("zero", int'(m_zero), (er == 0) ? 1 : 0);
      chk("overflow", int'(m_ovf), eovf);
    end
`endif
    prev_res  = er;
    prev_cout = ec;
    done_cyc  = cyc;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", int'(m_done), 0);
  endtask

  initial begin
    int d1, d2, busy_n, done_n;
    rst = 1'b1;
    drv_start = 1'b0;
    drv_a = '0;
    drv_b = '0;
    drv_sub = 1'b0;
    #12;
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_result", int'(m_res), 0);
    chk("rst_cout", int'(m_cout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycle();

    // Reset in the middle of an operation
    drv_start = 1'b1; drv_a = 8'h5; drv_b = 8'h3; drv_sub = 1'b0;
    @(posedge clk); #1;
    drv_start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", int'(m_busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(m_busy), 0);
    chk("midrst_done", int'(m_done), 0);
    chk("midrst_result", int'(m_res), 0);
    chk("midrst_cout", int'(m_cout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      busy_n += int'(m_busy);
      done_n += int'(m_done);
      @(posedge clk); #1;
    end
    chk("post_rst_busy", busy_n, 0);
    chk("post_rst_done", done_n, 0);
    prev_res = 0; prev_cout = 0;
    run_op(5, 3, 0, 0, d1);
    idle_cycle();

    // Directed corner cases
    run_op(15, 1, 0, 0, d1); idle_cycle();
    run_op(3, 5, 1, 0, d1);  idle_cycle();
    run_op(7, 7, 1, 0, d1);  idle_cycle();
    run_op(7, 1, 0, 0, d1);  idle_cycle();
    run_op(8, 1, 1, 0, d1);  idle_cycle();

    // Back-to-back with start held through DONE, noise on start while running
    run_op(2, 2, 0, 1, d1);
    run_op(9, 4, 0, 1, d2);
    chk("b2b_spacing", d2 - d1, 5);
    idle_cycle();

    // Exhaustive WIDTH=4 with random gaps
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++) begin
          run_op(a, b, s, 1, d1);
          if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    idle_cycle();

    // WIDTH=8 random operands
    sel = 8;
    prev_res = 0; prev_cout = 0;
    #1;
    chk("w8_idle_busy", int'(m_busy), 0);
    run_op(255, 1, 0, 0, d1);
    run_op(16, 200, 1, 1, d2);
    chk("w8_b2b_spacing", d2 - d1, 9);
    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), 1, d1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
